// File: rtl/dual_dev_arbiter_pkg.sv
// Shared types and defaults for the two-device round-robin arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    typedef logic owner_t;

    localparam int TIMEOUT_DEF = 16;
    localparam int CNT_W_DEF   = 16;

    // A tie goes to whichever device did not own the resource last.
    function automatic owner_t rr_pick(input logic [1:0] req, input owner_t last);
        return (req == 2'b11) ? owner_t'(~last) : owner_t'(req[1]);
    endfunction

endpackage

// File: rtl/dual_dev_arbiter_if.sv
// Request/grant handshake between the two devices and the arbiter.
interface dual_dev_arbiter_if;
    import arb_pkg::*;

    logic [1:0] req;
    logic [1:0] done;
    logic [1:0] gnt;
    owner_t     owner;
    logic       busy;
    logic       timeout_pulse;

    modport master (
        output req, done,
        input  gnt, owner, busy, timeout_pulse
    );

    modport slave (
        input  req, done,
        output gnt, owner, busy, timeout_pulse
    );

endinterface

// File: rtl/dual_dev_arbiter_sat_counter.sv
// Up-counter that sticks at all-ones; clear takes priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/dual_dev_arbiter.sv
// Round-robin owner arbitration for two devices with a hold watchdog and
// saturating grant / wait statistics.
module dual_dev_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    dual_dev_arbiter_if.slave bus,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1,
    output logic [CNT_W-1:0] wait_max
);

    localparam int HOLD_W = $clog2(TIMEOUT) + 1;

    state_t            state, state_d;
    owner_t            owner_d, pick;
    logic [1:0]        gnt_d;
    logic              busy_d, tp_d, take, hold_inc;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0]  wait0, wait1, wait_sel;

    always_comb begin
        state_d  = state;
        owner_d  = bus.owner;
        gnt_d    = bus.gnt;
        busy_d   = bus.busy;
        tp_d     = 1'b0;
        take     = 1'b0;
        hold_inc = 1'b0;
        pick     = rr_pick(bus.req, bus.owner);
        wait_sel = pick ? wait1 : wait0;
        case (state)
            IDLE, TURN: begin
                if (bus.req != 2'b00) begin
                    state_d = GRANT;
                    owner_d = pick;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    busy_d  = 1'b1;
                    take    = 1'b1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    busy_d  = 1'b0;
                end
            end
            GRANT: begin
                // done outranks the watchdog, so a coincident expiry is a clean release
                if (bus.done[bus.owner] || !bus.req[bus.owner]) begin
                    state_d = TURN;
                    gnt_d   = 2'b00;
                    busy_d  = 1'b0;
                end else if (hold_cnt == HOLD_W'(TIMEOUT - 1)) begin
                    state_d = TURN;
                    gnt_d   = 2'b00;
                    busy_d  = 1'b0;
                    tp_d    = 1'b1;
                end else begin
                    hold_inc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            bus.gnt           <= 2'b00;
            bus.owner         <= owner_t'(1'b1);
            bus.busy          <= 1'b0;
            bus.timeout_pulse <= 1'b0;
            wait_max          <= '0;
        end else begin
            state             <= state_d;
            bus.gnt           <= gnt_d;
            bus.owner         <= owner_d;
            bus.busy          <= busy_d;
            bus.timeout_pulse <= tp_d;
            if (take && (wait_sel > wait_max)) begin
                wait_max <= wait_sel;
            end
        end
    end

    sat_counter #(.W(HOLD_W)) u_hold (
        .clk(clk), .rst_n(rst_n), .clear(take), .inc(hold_inc), .count(hold_cnt)
    );

    sat_counter #(.W(CNT_W)) u_gnt0 (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .inc(take && !pick), .count(gnt_cnt0)
    );

    sat_counter #(.W(CNT_W)) u_gnt1 (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .inc(take && pick), .count(gnt_cnt1)
    );

    // Wait counters clear on the edge their device wins the resource.
    sat_counter #(.W(CNT_W)) u_wait0 (
        .clk(clk), .rst_n(rst_n), .clear(take && !pick),
        .inc(bus.req[0] && !bus.gnt[0]), .count(wait0)
    );

    sat_counter #(.W(CNT_W)) u_wait1 (
        .clk(clk), .rst_n(rst_n), .clear(take && pick),
        .inc(bus.req[1] && !bus.gnt[1]), .count(wait1)
    );

endmodule

// File: doc/dual_dev_arbiter.md
Name: dual_dev_arbiter

Overview:
- Two-requester arbiter sharing one resource (bus/engine) between device 1 and device 2.
- Each device holds a request until it signals completion. The arbiter grants exclusive ownership with round-robin fairness and enforces a watchdog hold limit.
- Sits between the two device models and the shared resource in the top-level. Its counters are exposed so sweep benches can check fairness and contention latency.

Parameters:
- TIMEOUT, 16, maximum cycles a grant may be held before forced release (must be >= 2).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  2  req[0]=device 1, req[1]=device 2; level, held until done or abandon.
- done  input  2  one-cycle completion pulse from the current owner.
- gnt  output  2  one-hot-or-zero grant, registered.
- owner  output  1  index of the current/last owner, registered.
- busy  output  1  high while in GRANT state.
- timeout_pulse  output  1  one-cycle pulse on watchdog release.
- gnt_cnt0  output  CNT_W  grants issued to device 1, saturating.
- gnt_cnt1  output  CNT_W  grants issued to device 2, saturating.
- wait_max  output  CNT_W  longest observed req-to-gnt latency (cycles), either device, saturating.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). All state and outputs are registered.
- Reset values:
  - gnt=0, owner=1 (so device 1 wins the first tie), busy=0, timeout_pulse=0.
  - All counters 0, state IDLE.
- States:
  - IDLE: no owner.
  - GRANT: owner holds the resource.
  - TURN: mandatory 1-cycle gnt-low gap after any release.
- Arbitration, evaluated in IDLE and TURN:
  - Only req[k] high -> grant k.
  - Both high -> grant !owner (round-robin).
  - None -> IDLE.
- Grant latency:
  - req sampled high at edge N in IDLE -> gnt[k]=1, busy=1 after edge N (visible in cycle N+1).
  - From TURN, a pending req is granted at the next edge, so the gnt-low gap is exactly 1 cycle.
- On entering GRANT:
  - owner<=k.
  - gnt_cntk increments, saturating at all-ones.
  - hold counter <=0.
  - wait_max is updated if that requester's wait counter exceeds it.
- Per-device wait counter:
  - Counts cycles with req[k]=1 and gnt[k]=0.
  - Clears when the grant is taken.
  - Saturates.
- GRANT exit conditions, in priority order:
  - done[owner]=1 -> TURN.
  - req[owner]=0 (abandon) -> TURN.
  - Hold counter == TIMEOUT-1 -> TURN, timeout_pulse=1 for one cycle.
  - Otherwise stay, hold counter +1.
- On any exit: gnt=0 and busy=0 after the same edge.
- done from the non-owner, or done in IDLE/TURN, is ignored with no side effects.
- done and timeout on the same edge: treated as a normal done; no timeout_pulse.
- A requester still asserting req after its done is eligible again from TURN. Round-robin still favours the other device if it is requesting.
- rst_n asserted mid-grant: gnt drops asynchronously. On release, the arbiter resumes from IDLE; counters are cleared.
- gnt is never multi-hot. gnt never changes owner without an intervening gnt=0 cycle.

Decomposition:
- Package arb_pkg:
  - state enum (IDLE, GRANT, TURN).
  - 1-bit owner typedef.
  - Default TIMEOUT/CNT_W constants.
- One sub-module: sat_counter (parameterised width; inc/clear inputs; saturates at all-ones). Instanced for the grant counters, wait counters and hold counter.
- Arbitration, FSM and wait_max compare stay in dual_dev_arbiter.

Test Plan:
- Single request: reset, req=01 at edge 5, done[0] pulse at edge 9 -> gnt=01 visible cycles 6..9, gnt=00 cycle 10, gnt_cnt0=1, gnt_cnt1=0.
- Simultaneous tie: req=11 from reset release, done pulsed 3 cycles after each grant -> grant order dev1, dev2, dev1, dev2, with one gnt=00 cycle between each; after 4 grants gnt_cnt0=2, gnt_cnt1=2.
- Watchdog: TIMEOUT=8, req=10 held, no done -> gnt=10 for exactly 8 cycles, timeout_pulse one cycle at the release edge, 1 gap cycle, then re-grant to device 2.
- Spurious done / abandon:
  - done[1] pulsed while device 1 owns -> no change.
  - Owner drops req without done -> gnt=00 next cycle, no timeout_pulse.
- Sweep contention: device 1 holds 5 cycles; device 2 request offset swept 0..12 cycles -> gnt never 11, wait_max <= 6, both grant counters equal the number of issued requests.
- Async reset mid-grant: rst_n low between edges while gnt=01 -> gnt=00 immediately, counters=0; after release with req=11 -> device 1 granted first.
